// File: rtl/friscv_rd_arbiter.sv
// Write-back arbiter: one pending Rd write slot per execution unit, one grant per
// cycle (round-robin or fixed priority), registered single-port register-file write.
module friscv_rd_arbiter #(
  parameter int XLEN    = 32,
  parameter int NB_UNIT = 3,
  parameter int RR_ARB  = 1
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      srst,
  input  logic [NB_UNIT-1:0]        req_valid,
  output logic [NB_UNIT-1:0]        req_ready,
  input  logic [NB_UNIT*5-1:0]      req_addr,
  input  logic [NB_UNIT*XLEN-1:0]   req_val,
  input  logic [NB_UNIT*XLEN/8-1:0] req_strb,
  output logic                      rd_wr,
  output logic [4:0]                rd_addr,
  output logic [XLEN-1:0]           rd_val,
  output logic [XLEN/8-1:0]         rd_strb,
  output logic [NB_UNIT-1:0]        slot_busy
);

  localparam int NBS  = XLEN / 8;
  localparam int PTRW = (NB_UNIT > 1) ? $clog2(NB_UNIT) : 1;

  logic [NB_UNIT-1:0] r_full;
  logic [4:0]         r_addr [NB_UNIT];
  logic [XLEN-1:0]    r_val  [NB_UNIT];
  logic [NBS-1:0]     r_strb [NB_UNIT];
  logic [PTRW-1:0]    r_ptr;

  logic [NB_UNIT-1:0] w_mask;
  logic [NB_UNIT-1:0] w_masked;
  logic [NB_UNIT-1:0] w_cand;
  logic [NB_UNIT-1:0] w_grant;
  logic [PTRW-1:0]    w_grant_idx;
  logic               w_grant_any;
  logic [NB_UNIT-1:0] w_accept;
  logic [NB_UNIT-1:0] w_load;

  // Round-robin: prefer full slots at or above the pointer, otherwise wrap to the
  // lowest full slot. With the mask forced to all ones this is plain fixed priority.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NB_UNIT; i++) begin
      w_mask[i] = (RR_ARB != 0) ? (PTRW'(i) >= r_ptr) : 1'b1;
    end
    w_masked    = r_full & w_mask;
    w_cand      = (|w_masked) ? w_masked : r_full;
    w_grant     = w_cand & (~w_cand + NB_UNIT'(1));
    w_grant_any = |r_full;
    w_grant_idx = '0;
    for (int i = NB_UNIT - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_grant_idx = PTRW'(i);
      end
    end
  end

  // A granted slot drains this cycle, so it may be refilled on the same edge.
  always_comb begin
    req_ready = ~r_full | w_grant;
    w_accept  = req_valid & req_ready;
    w_load    = '0;
    for (int i = 0; i < NB_UNIT; i++) begin
      w_load[i] = w_accept[i] & (req_addr[i*5 +: 5] != 5'd0);
    end
  end

  assign slot_busy = r_full;

  // Slot registers; an accepted x0 write is simply not loaded, so a granted slot
  // receiving it still drains.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_full <= '0;
      for (int i = 0; i < NB_UNIT; i++) begin
        r_addr[i] <= '0;
        r_val[i]  <= '0;
        r_strb[i] <= '0;
      end
    end else if (srst) begin
      r_full <= '0;
    end else begin
      for (int i = 0; i < NB_UNIT; i++) begin
        if (w_load[i]) begin
          r_full[i] <= 1'b1;
          r_addr[i] <= req_addr[i*5 +: 5];
          r_val[i]  <= req_val[i*XLEN +: XLEN];
          r_strb[i] <= req_strb[i*NBS +: NBS];
        end else if (w_grant[i]) begin
          r_full[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_ptr <= '0;
    end else if (srst) begin
      r_ptr <= '0;
    end else if (w_grant_any && (RR_ARB != 0)) begin
      r_ptr <= (w_grant_idx == PTRW'(NB_UNIT - 1)) ? '0 : w_grant_idx + PTRW'(1);
    end
  end

  // Data outputs hold their last value between writes; only the enable pulses.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_wr   <= 1'b0;
      rd_addr <= '0;
      rd_val  <= '0;
      rd_strb <= '0;
    end else if (srst) begin
      rd_wr   <= 1'b0;
      rd_addr <= '0;
      rd_val  <= '0;
      rd_strb <= '0;
    end else if (w_grant_any) begin
      rd_wr   <= 1'b1;
      rd_addr <= r_addr[w_grant_idx];
      rd_val  <= r_val[w_grant_idx];
      rd_strb <= r_strb[w_grant_idx];
    end else begin
      rd_wr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_friscv_rd_arbiter.sv
// Directed scoreboard bench for friscv_rd_arbiter: a round-robin and a fixed-priority
// instance share stimulus; each phase checks the instance it targets.
module tb_friscv_rd_arbiter;

  localparam int XLEN = 32;
  localparam int NBU  = 3;

  logic                  aclk = 1'b0;
  logic                  aresetn;
  logic                  srst;
  logic [NBU-1:0]        reqValid;
  logic [NBU*5-1:0]      reqAddr;
  logic [NBU*XLEN-1:0]   reqVal;
  logic [NBU*XLEN/8-1:0] reqStrb;

  logic [NBU-1:0]    rrReady, fpReady;
  logic              rrWr, fpWr;
  logic [4:0]        rrAddr, fpAddr;
  logic [XLEN-1:0]   rrVal, fpVal;
  logic [XLEN/8-1:0] rrStrb, fpStrb;
  logic [NBU-1:0]    rrBusy, fpBusy;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] val;
    logic [3:0]  strb;
  } wrT;

  wrT sbQ[$];
  int errorCount = 0;
  int checkCount = 0;
  bit useFp = 1'b0;

  logic           obsWr;
  logic [4:0]     obsAddr;
  logic [31:0]    obsVal;
  logic [3:0]     obsStrb;
  logic [NBU-1:0] obsReady;
  logic [NBU-1:0] obsBusy;

  friscv_rd_arbiter #(.XLEN(XLEN), .NB_UNIT(NBU), .RR_ARB(1)) dutRr (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .req_valid(reqValid), .req_ready(rrReady), .req_addr(reqAddr),
    .req_val(reqVal), .req_strb(reqStrb),
    .rd_wr(rrWr), .rd_addr(rrAddr), .rd_val(rrVal), .rd_strb(rrStrb),
    .slot_busy(rrBusy)
  );

  friscv_rd_arbiter #(.XLEN(XLEN), .NB_UNIT(NBU), .RR_ARB(0)) dutFp (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .req_valid(reqValid), .req_ready(fpReady), .req_addr(reqAddr),
    .req_val(reqVal), .req_strb(reqStrb),
    .rd_wr(fpWr), .rd_addr(fpAddr), .rd_val(fpVal), .rd_strb(fpStrb),
    .slot_busy(fpBusy)
  );

  always #5 aclk = ~aclk;

  task automatic sampleOutputs();
    if (useFp) begin
      obsWr = fpWr; obsAddr = fpAddr; obsVal = fpVal; obsStrb = fpStrb;
      obsReady = fpReady; obsBusy = fpBusy;
    end else begin
      obsWr = rrWr; obsAddr = rrAddr; obsVal = rrVal; obsStrb = rrStrb;
      obsReady = rrReady; obsBusy = rrBusy;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic pushExpected(input logic [4:0] a, input logic [31:0] v, input logic [3:0] s);
    wrT e;
    e.addr = a; e.val = v; e.strb = s;
    sbQ.push_back(e);
  endtask

  task automatic applyStimulus(input int unit, input logic valid, input logic [4:0] a,
                               input logic [31:0] v, input logic [3:0] s);
    reqValid[unit]           = valid;
    reqAddr[unit*5 +: 5]     = a;
    reqVal[unit*XLEN +: XLEN] = v;
    reqStrb[unit*4 +: 4]     = s;
  endtask

  task automatic idleAll();
    reqValid = '0;
  endtask

  // Every observed write must match the oldest outstanding expected write.
  task automatic step();
    wrT e;
    @(posedge aclk);
    #1;
    sampleOutputs();
    if (obsWr) begin
      if (sbQ.size() == 0) begin
        checkOutput("sb_unexpected_wr", {63'd0, obsWr}, 64'd0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("sb_addr", {59'd0, obsAddr}, {59'd0, e.addr});
        checkOutput("sb_val", {32'd0, obsVal}, {32'd0, e.val});
        checkOutput("sb_strb", {60'd0, obsStrb}, {60'd0, e.strb});
      end
    end
  endtask

  task automatic doSrst();
    idleAll();
    srst = 1'b1;
    step();
    srst = 1'b0;
  endtask

  initial begin
    aresetn = 1'b0;
    srst    = 1'b0;
    reqValid = '0;
    reqAddr  = '0;
    reqVal   = '0;
    reqStrb  = '0;
    #12;
    sampleOutputs();
    checkOutput("reset_wr", obsWr, 0);
    checkOutput("reset_addr", obsAddr, 0);
    checkOutput("reset_val", obsVal, 0);
    checkOutput("reset_strb", obsStrb, 0);
    checkOutput("reset_ready", obsReady, 3'b111);
    checkOutput("reset_busy", obsBusy, 0);
    checkOutput("reset_fp_wr", fpWr, 0);
    aresetn = 1'b1;

    // Single write from unit 1
    useFp = 1'b0;
    applyStimulus(1, 1'b1, 5'd5, 32'hDEADBEEF, 4'hF);
    pushExpected(5'd5, 32'hDEADBEEF, 4'hF);
    checkOutput("single_ready_pre", obsReady[1], 1);
    step();
    idleAll();
    checkOutput("single_wr_early", obsWr, 0);
    checkOutput("single_busy", obsBusy, 3'b010);
    checkOutput("single_ready_full", obsReady[1], 1);
    step();
    checkOutput("single_wr", obsWr, 1);
    checkOutput("single_ready_after", obsReady[1], 1);
    step();
    checkOutput("single_wr_once", obsWr, 0);
    checkOutput("single_drained", sbQ.size(), 0);

    // Round-robin fairness with all units streaming
    doSrst();
    for (int u = 0; u < NBU; u++) applyStimulus(u, 1'b1, 5'(u + 1), 32'h100 + u + 1, 4'hF);
    for (int j = 0; j < 9; j++) pushExpected(5'(j % 3 + 1), 32'h101 + (j % 3), 4'hF);
    for (int k = 1; k <= 11; k++) begin
      step();
      if (k <= 7) checkOutput($sformatf("rr_ready_e%0d", k), obsReady, 1 << ((k - 1) % 3));
      if (k >= 2 && k <= 10) begin
        checkOutput($sformatf("rr_wr_e%0d", k), obsWr, 1);
        checkOutput($sformatf("rr_addr_e%0d", k), obsAddr, (k - 2) % 3 + 1);
      end else begin
        checkOutput($sformatf("rr_idle_e%0d", k), obsWr, 0);
      end
      if (k == 7) idleAll();
    end
    checkOutput("rr_drained", sbQ.size(), 0);

    // Fixed priority: unit 0 starves unit 2 while it keeps its slot full
    useFp = 1'b1;
    doSrst();
    applyStimulus(0, 1'b1, 5'd4, 32'hA4, 4'hF);
    applyStimulus(2, 1'b1, 5'd6, 32'hA6, 4'hF);
    for (int j = 0; j < 5; j++) pushExpected(5'd4, 32'hA4, 4'hF);
    for (int j = 0; j < 2; j++) pushExpected(5'd6, 32'hA6, 4'hF);
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k <= 5) checkOutput($sformatf("fp_ready2_e%0d", k), obsReady[2], 0);
      if (k >= 2 && k <= 6) checkOutput($sformatf("fp_addr0_e%0d", k), obsAddr, 4);
      if (k == 7 || k == 8) checkOutput($sformatf("fp_addr2_e%0d", k), obsAddr, 6);
      checkOutput($sformatf("fp_wr_e%0d", k), obsWr, (k >= 2 && k <= 8) ? 1 : 0);
      if (k == 5) applyStimulus(0, 1'b0, 5'd4, 32'hA4, 4'hF);
      if (k == 7) applyStimulus(2, 1'b0, 5'd6, 32'hA6, 4'hF);
    end
    checkOutput("fp_drained", sbQ.size(), 0);
    useFp = 1'b0;

    // x0 writes are dropped
    doSrst();
    applyStimulus(0, 1'b1, 5'd0, 32'h1234, 4'hF);
    step();
    checkOutput("x0_busy", obsBusy, 0);
    checkOutput("x0_wr", obsWr, 0);
    applyStimulus(0, 1'b1, 5'd7, 32'h55, 4'hF);
    pushExpected(5'd7, 32'h55, 4'hF);
    step();
    idleAll();
    checkOutput("x0_wr_still0", obsWr, 0);
    checkOutput("x0_busy_loaded", obsBusy, 3'b001);
    step();
    checkOutput("x0_real_wr", obsWr, 1);
    step();
    checkOutput("x0_wr_end", obsWr, 0);
    step();
    checkOutput("x0_wr_end2", obsWr, 0);
    checkOutput("x0_drained", sbQ.size(), 0);

    // Back-to-back stream from unit 2
    doSrst();
    for (int j = 0; j < 4; j++) begin
      applyStimulus(2, 1'b1, 5'(8 + j), 32'h200 + j, 4'h3);
      pushExpected(5'(8 + j), 32'h200 + j, 4'h3);
      step();
      checkOutput($sformatf("b2b_ready_%0d", j), obsReady[2], 1);
      checkOutput($sformatf("b2b_wr_%0d", j), obsWr, (j >= 1) ? 1 : 0);
    end
    idleAll();
    step();
    checkOutput("b2b_wr_last", obsWr, 1);
    checkOutput("b2b_addr_last", obsAddr, 11);
    step();
    checkOutput("b2b_wr_end", obsWr, 0);
    checkOutput("b2b_drained", sbQ.size(), 0);

    // Synchronous reset with pending slots, then pointer restart
    doSrst();
    applyStimulus(0, 1'b1, 5'd12, 32'h30C, 4'hF);
    applyStimulus(1, 1'b1, 5'd13, 32'h30D, 4'hF);
    applyStimulus(2, 1'b1, 5'd14, 32'h30E, 4'hF);
    pushExpected(5'd12, 32'h30C, 4'hF);
    step();
    idleAll();
    checkOutput("srst_busy_full", obsBusy, 3'b111);
    checkOutput("srst_wr_pre", obsWr, 0);
    step();
    checkOutput("srst_first_wr", obsWr, 1);
    checkOutput("srst_busy_pre", obsBusy, 3'b110);
    checkOutput("srst_ready_pre", obsReady, 3'b011);
    srst = 1'b1;
    step();
    srst = 1'b0;
    checkOutput("srst_busy", obsBusy, 0);
    checkOutput("srst_wr", obsWr, 0);
    checkOutput("srst_ready", obsReady, 3'b111);
    step();
    checkOutput("srst_wr_after", obsWr, 0);
    applyStimulus(0, 1'b1, 5'd20, 32'h414, 4'hC);
    applyStimulus(2, 1'b1, 5'd22, 32'h416, 4'h1);
    pushExpected(5'd20, 32'h414, 4'hC);
    pushExpected(5'd22, 32'h416, 4'h1);
    step();
    idleAll();
    checkOutput("ptr_wr_pre", obsWr, 0);
    step();
    checkOutput("ptr_first_addr", obsAddr, 20);
    step();
    checkOutput("ptr_second_addr", obsAddr, 22);
    step();
    checkOutput("ptr_wr_end", obsWr, 0);
    checkOutput("ptr_drained", sbQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
